// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned 4x3 keypad with press/release debounce and one strobe per press
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] data,
  output logic       is_pressed,
  output logic       is_star_pressed,
  output logic       is_hash_pressed,
  output logic       key_strobe
);
  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_DONE = CW'(DEBOUNCE_CYC);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  state_t state, state_n;
  logic [3:0] sync1, srow, inv, key, code, code_n, data_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0] col_n, col_rot;
  logic [1:0] ridx, ridx_n, row_sel, col_sel;
  logic one_low, watched, pr_n, st_n, hs_n, strobe_n;
  assign inv     = ~srow;
  assign one_low = (inv != 4'd0) && ((inv & (inv - 4'd1)) == 4'd0);
  assign row_sel = inv[0] ? 2'd0 : inv[1] ? 2'd1 : inv[2] ? 2'd2 : 2'd3;
  assign col_sel = !col[0] ? 2'd0 : !col[1] ? 2'd1 : 2'd2;
  // bottom row holds *, 0, # rather than continuing the 1..9 pattern
  assign key     = (row_sel == 2'd3) ? ((col_sel == 2'd0) ? 4'd10 : (col_sel == 2'd1) ? 4'd0 : 4'd11)
                                     : {2'b00, row_sel} * 4'd3 + {2'b00, col_sel} + 4'd1;
  assign col_rot = {col[1:0], col[2]};
  assign watched = srow[ridx];
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);
  always_comb begin
    state_n  = state;
    dwell_n  = dwell;
    cnt_n    = cnt;
    col_n    = col;
    ridx_n   = ridx;
    code_n   = code;
    data_n   = data;
    pr_n     = is_pressed;
    st_n     = is_star_pressed;
    hs_n     = is_hash_pressed;
    strobe_n = 1'b0;
    if (!en) begin
      state_n = SCAN;
      dwell_n = '0;
      cnt_n   = '0;
      col_n   = 3'b111;
      pr_n    = 1'b0;
      st_n    = 1'b0;
      hs_n    = 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (col == 3'b111) begin
            col_n   = 3'b110;
            dwell_n = '0;
          end else if (dwell != DWELL_LAST) begin
            dwell_n = dwell + DW'(1);
          end else begin
            dwell_n = '0;
            if (one_low) begin
              state_n = DEBOUNCE;
              ridx_n  = row_sel;
              code_n  = key;
              cnt_n   = '0;
            end else begin
              col_n = col_rot;
            end
          end
        end
        DEBOUNCE: begin
          if (watched) begin
            state_n = SCAN;
            cnt_n   = '0;
            dwell_n = '0;
            col_n   = col_rot;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_DONE) begin
              state_n  = PRESSED;
              cnt_n    = '0;
              data_n   = code;
              pr_n     = code < 4'd10;
              st_n     = code == 4'd10;
              hs_n     = code == 4'd11;
              strobe_n = 1'b1;
            end
          end
        end
        PRESSED: begin
          if (watched) begin
            state_n = RELEASE;
            cnt_n   = '0;
          end
        end
        default: begin
          if (!watched) begin
            state_n = PRESSED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_DONE) begin
              state_n = SCAN;
              cnt_n   = '0;
              dwell_n = '0;
              col_n   = col_rot;
              pr_n    = 1'b0;
              st_n    = 1'b0;
              hs_n    = 1'b0;
            end
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1           <= 4'hf;
      srow            <= 4'hf;
      state           <= SCAN;
      dwell           <= '0;
      cnt             <= '0;
      col             <= 3'b110;
      ridx            <= 2'd0;
      code            <= 4'd0;
      data            <= 4'd0;
      is_pressed      <= 1'b0;
      is_star_pressed <= 1'b0;
      is_hash_pressed <= 1'b0;
      key_strobe      <= 1'b0;
    end else begin
      sync1           <= row;
      srow            <= sync1;
      state           <= state_n;
      dwell           <= dwell_n;
      cnt             <= cnt_n;
      col             <= col_n;
      ridx            <= ridx_n;
      code            <= code_n;
      data            <= data_n;
      is_pressed      <= pr_n;
      is_star_pressed <= st_n;
      is_hash_pressed <= hs_n;
      key_strobe      <= strobe_n;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus directed and randomized press checks
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic en = 1'b0;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] data;
  logic is_pressed, is_star_pressed, is_hash_pressed, key_strobe;
  logic [2:0] held [4];
  int checks = 0, passes = 0;
  int strobes = 0, flag_cycles = 0, excl_bad = 0, col_bad = 0, col_moves = 0, strobe_wide = 0;
  logic prev_strobe = 1'b0;
  logic [2:0] prev_col = 3'b110;
  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .row(row), .col(col), .data(data),
    .is_pressed(is_pressed), .is_star_pressed(is_star_pressed),
    .is_hash_pressed(is_hash_pressed), .key_strobe(key_strobe)
  );
  always #5 clk = ~clk;
  // a held key shorts its row to its column only while that column is driven low
  assign row = {~|(held[3] & ~col), ~|(held[2] & ~col), ~|(held[1] & ~col), ~|(held[0] & ~col)};
  always @(posedge clk) begin
    #1;
    if (key_strobe) strobes++;
    if (key_strobe && prev_strobe) strobe_wide++;
    if (is_pressed || is_star_pressed || is_hash_pressed) flag_cycles++;
    if (32'(is_pressed) + 32'(is_star_pressed) + 32'(is_hash_pressed) > 1) excl_bad++;
    if (!(col inside {3'b110, 3'b101, 3'b011, 3'b111})) col_bad++;
    if (col != prev_col) col_moves++;
    prev_strobe = key_strobe;
    prev_col = col;
  end
  function automatic logic [3:0] model_code(input int r, input int c);
    string layout = "123456789*0#";
    byte ch = layout[r * 3 + c];
    return (ch == "*") ? 4'd10 : (ch == "#") ? 4'd11 : 4'(ch - "0");
  endfunction
  function automatic logic [2:0] model_flags(input logic [3:0] k);
    return (k < 4'd10) ? 3'b100 : (k == 4'd10) ? 3'b010 : 3'b001;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!key_strobe && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, " strobe"}, 32'(key_strobe), 1);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((is_pressed || is_star_pressed || is_hash_pressed) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, {is_pressed, is_star_pressed, is_hash_pressed}, 0);
  endtask
  initial begin
    int s0, f0, m0, r, c, n;
    logic [3:0] k;
    logic [2:0] pc;
    for (int i = 0; i < 4; i++) held[i] = 3'b000;
    en = 1'b1;
    #2 reset_n = 1'b0;
    tick(3);
    check("rst col", col, 3'b110);
    check("rst data", data, 0);
    check("rst flags", {is_pressed, is_star_pressed, is_hash_pressed}, 0);
    check("rst strobe", key_strobe, 0);
    reset_n = 1'b1;
    tick(4);
    check("rot 101", col, 3'b101);
    tick(4);
    check("rot 011", col, 3'b011);
    tick(4);
    check("rot 110", col, 3'b110);
    s0 = strobes;
    held[1][1] = 1'b1;
    wait_strobe("five");
    check("five data", data, model_code(1, 1));
    check("five flags", {is_pressed, is_star_pressed, is_hash_pressed}, 3'b100);
    tick(20);
    check("five col frozen", col, 3'b101);
    check("five held", is_pressed, 1);
    check("five one strobe", strobes - s0, 1);
    held[1][1] = 1'b0;
    tick(8);
    check("five release hold", is_pressed, 1);
    tick(4);
    check("five release fall", {is_pressed, is_star_pressed, is_hash_pressed}, 0);
    s0 = strobes;
    f0 = flag_cycles;
    for (int i = 0; i < 10; i++) begin
      held[2][0] = ~held[2][0];
      tick(3);
    end
    held[2][0] = 1'b0;
    check("bounce no strobe", strobes - s0, 0);
    check("bounce no flag", flag_cycles - f0, 0);
    held[2][0] = 1'b1;
    wait_strobe("seven");
    check("seven data", data, model_code(2, 0));
    tick(10);
    held[2][0] = 1'b0;
    tick(5);
    held[2][0] = 1'b1;
    tick(20);
    check("glitch one strobe", strobes - s0, 1);
    check("glitch held", is_pressed, 1);
    held[2][0] = 1'b0;
    wait_idle("seven");
    held[3][0] = 1'b1;
    wait_strobe("star");
    check("star data", data, 4'b1010);
    check("star flags", {is_pressed, is_star_pressed, is_hash_pressed}, 3'b010);
    held[3][0] = 1'b0;
    wait_idle("star");
    check("star data kept", data, 4'b1010);
    held[3][2] = 1'b1;
    wait_strobe("hash");
    check("hash data", data, 4'b1011);
    check("hash flags", {is_pressed, is_star_pressed, is_hash_pressed}, 3'b001);
    held[3][2] = 1'b0;
    wait_idle("hash");
    s0 = strobes;
    m0 = col_moves;
    held[0][0] = 1'b1;
    held[3][0] = 1'b1;
    tick(60);
    check("ghost no strobe", strobes - s0, 0);
    check("ghost rotating", 32'(col_moves - m0 >= 10), 1);
    held[0][0] = 1'b0;
    held[3][0] = 1'b0;
    tick(4);
    for (int t = 0; t < 8; t++) begin
      r = $urandom_range(3, 0);
      c = $urandom_range(2, 0);
      k = model_code(r, c);
      s0 = strobes;
      repeat ($urandom_range(3, 1)) begin
        held[r][c] = 1'b1;
        tick($urandom_range(5, 1));
        held[r][c] = 1'b0;
        tick($urandom_range(4, 1));
      end
      check("rand bounce", strobes - s0, 0);
      held[r][c] = 1'b1;
      wait_strobe("rand");
      check("rand data", data, k);
      check("rand flags", {is_pressed, is_star_pressed, is_hash_pressed}, model_flags(k));
      tick($urandom_range(40, 10));
      if (t % 2 == 1) begin
        held[r][c] = 1'b0;
        tick(3);
        held[r][c] = 1'b1;
        tick(15);
      end
      check("rand one strobe", strobes - s0, 1);
      check("rand still held", {is_pressed, is_star_pressed, is_hash_pressed}, model_flags(k));
      held[r][c] = 1'b0;
      wait_idle("rand");
      check("rand data kept", data, k);
      tick($urandom_range(10, 1));
    end
    held[0][0] = 1'b1;
    wait_strobe("one");
    check("one data", data, 4'd1);
    tick(3);
    check("one held", is_pressed, 1);
    en = 1'b0;
    tick(1);
    check("dis flags", {is_pressed, is_star_pressed, is_hash_pressed}, 0);
    check("dis col", col, 3'b111);
    check("dis strobe", key_strobe, 0);
    tick(5);
    check("dis col stays", col, 3'b111);
    en = 1'b1;
    tick(1);
    check("en col", col, 3'b110);
    s0 = strobes;
    wait_strobe("reenable");
    check("reenable data", data, 4'd1);
    check("reenable count", strobes - s0, 1);
    held[0][0] = 1'b0;
    wait_idle("one");
    n = 0;
    pc = col;
    @(negedge clk);
    while (!(col == 3'b110 && pc != 3'b110) && n < 40) begin
      pc = col;
      @(negedge clk);
      n++;
    end
    check("col0 found", 32'(col == 3'b110), 1);
    held[0][0] = 1'b1;
    tick(7);
    s0 = strobes;
    reset_n = 1'b0;
    #1;
    check("mid rst col", col, 3'b110);
    check("mid rst data", data, 0);
    check("mid rst flags", {is_pressed, is_star_pressed, is_hash_pressed, key_strobe}, 0);
    tick(10);
    check("mid rst no strobe", strobes - s0, 0);
    check("mid rst col hold", col, 3'b110);
    held[0][0] = 1'b0;
    check("exclusive flags", excl_bad, 0);
    check("col legal", col_bad, 0);
    check("strobe width", strobe_wide, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the safe's 4x3 matrix keypad and produces the debounced key stream consumed by the password comparator.
- Outputs the comparator's inputs: BCD digit `data`, `is_pressed` for digits, `is_star_pressed` for `*`, plus `is_hash_pressed` and a one-cycle `key_strobe`.
- Sits between the keypad pins and the comparator/controller. It drives one keypad column at a time, reads the row lines, and reports exactly one event per physical press.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before moving to the next column; must be >= 4.
- DEBOUNCE_CYC, 20000: consecutive stable cycles required to accept a press and to accept a release; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- en  input  1  scanner enable; tied to the safe's `is_on`.
- row  input  4  keypad rows, active-low with external pull-ups; row[0] is the top row.
- col  output  3  keypad column drive, active-low, one-hot-zero; col[0] is the left column.
- data  output  4  key code. Digits 0-9 are 8421 BCD; `*` = 4'b1010; `#` = 4'b1011.
- is_pressed  output  1  high while an accepted digit key is held.
- is_star_pressed  output  1  high while an accepted `*` key is held.
- is_hash_pressed  output  1  high while an accepted `#` key is held.
- key_strobe  output  1  one-cycle pulse when a press is accepted.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `reset_n` is asynchronous and active-low.
- Key map (row, col):
  - col0: 1, 4, 7, `*`
  - col1: 2, 5, 8, 0
  - col2: 3, 6, 9, `#`
- Row synchronisation: `row` passes through a 2-flop synchroniser. All decisions use the synchronised value `srow`.
- Reset values: state = SCAN, `col` = 3'b110, `data` = 4'b0000, all flags = 0, all counters = 0.
- SCAN state:
  - A dwell counter runs 0..SCAN_DIV-1.
  - On the last dwell cycle, `srow` is sampled.
  - If exactly one bit of `srow` is 0: capture row index, column index and key code; go to DEBOUNCE; `col` stays frozen.
  - If zero bits or two or more bits are 0: rotate `col` (110 -> 101 -> 011 -> 110) and restart the dwell.
- DEBOUNCE state:
  - The counter increments each cycle that `srow[captured]` = 0.
  - Any cycle with `srow[captured]` = 1 returns to SCAN, clears the counter, and rotates to the next column.
  - When the count reaches DEBOUNCE_CYC, go to PRESSED on that clock edge. On the same edge:
    - `data` takes the code;
    - the matching flag (`is_pressed`, `is_star_pressed` or `is_hash_pressed`) is set;
    - `key_strobe` = 1 for exactly that one cycle.
- PRESSED state: outputs hold. When `srow[captured]` = 1, go to RELEASE with the counter cleared.
- RELEASE state:
  - The counter increments each cycle that `srow[captured]` = 1.
  - If `srow[captured]` = 0 before the count completes, return to PRESSED with no new strobe.
  - At DEBOUNCE_CYC: clear all flags, go to SCAN, rotate to the next column.
  - `data` keeps its last value until the next accepted press.
- Exclusivity: at most one of the three flags is high at any time. Flags change only on accept and release edges.
- Other keys while a key is held: ignored, because only the captured row and column are watched.
- `en` = 0 (synchronous): next edge forces state SCAN, counters 0, flags 0, `key_strobe` 0, `col` = 3'b111. When `en` returns to 1, scanning restarts at `col` = 3'b110.
- Reset mid-operation: any state returns immediately to the reset values. No strobe is issued.
- Counter widths: $clog2 of the parameter, plus 1 bit. Counters saturate; they never wrap.
- Latency from a clean, steady press (key in the driven column) to the strobe: at most 2 (sync) + SCAN_DIV×3 + DEBOUNCE_CYC + 1 cycles.

Test Plan (all scenarios use SCAN_DIV=4, DEBOUNCE_CYC=8):
- Reset: hold `reset_n`=0 with `row`=4'b1111 -> `col`=3'b110, `data`=4'b0000, all flags 0, `key_strobe`=0. Release reset -> `col` steps 110, 101, 011 every 4 cycles.
- Clean `5`: drive row[1]=0 whenever `col`=3'b101, held for 60 cycles, then release:
  - `key_strobe` pulses once; `is_pressed`=1; `data`=4'b0101; `col` frozen at 3'b101 while held;
  - `is_pressed` falls 8 cycles after the synchronised release;
  - `is_star_pressed` and `is_hash_pressed` stay 0.
- Bounce: key `7` (row[2], col0) toggles every 3 cycles for 30 cycles, then is held steady for 20 -> exactly one `key_strobe`, `data`=4'b0111, no flag activity during the bounce. A 5-cycle release glitch while held -> no second strobe.
- `*` then `#` in sequence:
  - `*` -> `is_star_pressed`=1, `data`=4'b1010, `is_pressed`=0;
  - after release, `#` -> `is_hash_pressed`=1, `data`=4'b1011.
- Ghost/multi-key: rows 0 and 3 both low in col0 -> no strobe, `col` continues rotating.
- Disable and reset mid-operation:
  - `en`=0 while `1` is held in PRESSED -> next cycle all flags 0 and `col`=3'b111;
  - `en`=1 -> scanning resumes at 3'b110 and the still-held key produces a new strobe;
  - `reset_n`=0 during DEBOUNCE -> `col`=3'b110 and no strobe.
